// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: stage occupancy states, control-bundle
// field offsets and per-stage control widths / NOP values.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } stage_state_t;

  // Control bundle field offsets (bit positions within the packed control word).
  localparam int ALU_OP_LSB   = 0;
  localparam int ALU_OP_W     = 4;
  localparam int RF_EN        = 4;
  localparam int HI_EN        = 5;
  localparam int LO_EN        = 6;
  localparam int MEM_EN       = 7;
  localparam int MEM_RW       = 8;
  localparam int MEM_SIZE_LSB = 9;
  localparam int MEM_SIZE_W   = 2;
  localparam int MEM_SIGNE    = 11;
  localparam int LOAD         = 12;
  localparam int PC8          = 13;
  localparam int CTRL_FULL_W  = 14;

  localparam int IFID_CTRL_W  = 1;
  localparam int IDEX_CTRL_W  = CTRL_FULL_W;
  localparam int EXMEM_CTRL_W = CTRL_FULL_W;
  localparam int MEMWB_CTRL_W = CTRL_FULL_W;

  localparam logic [IFID_CTRL_W-1:0]  IFID_CTRL_NOP  = '0;
  localparam logic [IDEX_CTRL_W-1:0]  IDEX_CTRL_NOP  = '0;
  localparam logic [EXMEM_CTRL_W-1:0] EXMEM_CTRL_NOP = '0;
  localparam logic [MEMWB_CTRL_W-1:0] MEMWB_CTRL_NOP = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, cleared by Reset.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: default assigned first so every path drives count_d and no latch is inferred.
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Clk) begin
    if (Reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid
// buffer (registered in_ready), flush-to-bubble and saturating perf counters.
module pipe_stage_skid #(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
  parameter bit                SKID     = 1'b1,
  parameter int                CNT_W    = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // States are package-scoped because the SKID parameter shadows the enum literal.
  pipe_pkg::stage_state_t state_q, state_d;

  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic              main_load, main_from_skid, skid_load;
  logic              accept, consume;

  assign out_valid = (state_q != pipe_pkg::EMPTY);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_d = pipe_pkg::EMPTY;
    end else begin
      unique case (state_q)
        pipe_pkg::EMPTY: if (accept) begin
          state_d   = pipe_pkg::FULL;
          main_load = 1'b1;
        end
        pipe_pkg::FULL: begin
          if (accept && consume) begin
            main_load = 1'b1;
          end else if (accept) begin
            state_d   = pipe_pkg::SKID;
            skid_load = 1'b1;
          end else if (consume) begin
            state_d = pipe_pkg::EMPTY;
          end
        end
        pipe_pkg::SKID: if (consume) begin
          state_d        = pipe_pkg::FULL;
          main_from_skid = 1'b1;
        end
        default: state_d = pipe_pkg::EMPTY;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= pipe_pkg::EMPTY;
      main_ctrl_q <= CTRL_NOP;
      main_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (main_load) begin
        main_ctrl_q <= in_ctrl;
        main_data_q <= in_data;
      end else if (main_from_skid) begin
        main_ctrl_q <= skid_ctrl_q;
        main_data_q <= skid_data_q;
      end
    end
  end

  if (SKID) begin : g_skid
    logic rdy_q;

    // NOTE: skid entries are reset too, so nothing undefined can ever reach out_data.
    always_ff @(posedge Clk) begin
      if (Reset) begin
        skid_ctrl_q <= CTRL_NOP;
        skid_data_q <= '0;
        rdy_q       <= 1'b0;
      end else begin
        rdy_q <= (state_d != pipe_pkg::SKID);
        if (skid_load) begin
          skid_ctrl_q <= in_ctrl;
          skid_data_q <= in_data;
        end
      end
    end

    assign in_ready = rdy_q && !Reset;
  end else begin : g_noskid
    assign skid_ctrl_q = CTRL_NOP;
    assign skid_data_q = '0;
    assign in_ready    = !Reset && (!out_valid || out_ready);
  end

  // Control is masked whenever nothing valid is held; data keeps its last value.
  assign out_ctrl = out_valid ? main_ctrl_q : CTRL_NOP;
  assign out_data = main_data_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .inc   (out_valid && !out_ready),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .inc   (!out_valid),
    .count (bubble_cnt)
  );

endmodule
